// File: rtl/epochtv1_pkg.sv
// Shared Epoch TV-1 definitions: host address map, region decode, host bus states.
package epochtv1_pkg;

   localparam logic [12:0] VRAM_BASE     = 13'h0000;
   localparam logic [12:0] BGM_BASE      = 13'h1000;
   localparam logic [12:0] OAM_BASE      = 13'h1200;
   localparam logic [12:0] REG_BASE      = 13'h1400;
   localparam logic [12:0] UNMAPPED_BASE = 13'h1600;

   typedef enum logic [1:0] {
      HBUS_IDLE,
      HBUS_SETUP,
      HBUS_STROBE,
      HBUS_HOLD
   } e_hbus_st;

   typedef enum logic [2:0] {
      RGN_VRAM,
      RGN_BGM,
      RGN_OAM,
      RGN_REG,
      RGN_UNMAPPED
   } e_region;

   typedef struct packed {
      logic        we;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic [12:0] count;
   } hbus_req_t;

   function automatic e_region region_of(input logic [12:0] addr);
      if (addr >= UNMAPPED_BASE)  return RGN_UNMAPPED;
      else if (addr >= REG_BASE)  return RGN_REG;
      else if (addr >= OAM_BASE)  return RGN_OAM;
      else if (addr >= BGM_BASE)  return RGN_BGM;
      else                        return RGN_VRAM;
   endfunction

   function automatic logic [12:0] region_base(input e_region rgn);
      case (rgn)
         RGN_BGM:  return BGM_BASE;
         RGN_OAM:  return OAM_BASE;
         RGN_REG:  return REG_BASE;
         RGN_VRAM: return VRAM_BASE;
         default:  return UNMAPPED_BASE;
      endcase
   endfunction

   function automatic logic is_unmapped(input logic [12:0] addr);
      return region_of(addr) == RGN_UNMAPPED;
   endfunction

endpackage

// File: rtl/epochtv1_host_bus.sv
// Host-side uPD7801-style bus initiator: single reads/writes and fill bursts,
// every bus phase timed in pixel-clock enables.
module epochtv1_host_bus
   import epochtv1_pkg::*;
#(
   parameter int SETUP_CE  = 1,
   parameter int STROBE_CE = 2,
   parameter int HOLD_CE   = 1
) (
   input  logic        CLK,
   input  logic        RESB,
   input  logic        CE,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [12:0] REQ_ADDR,
   input  logic [7:0]  REQ_WDATA,
   input  logic [12:0] REQ_COUNT,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_RDATA,
   output logic        RSP_ERR,
   output logic [12:0] A,
   output logic [7:0]  DB_O,
   output logic        DB_OE,
   input  logic [7:0]  DB_I,
   output logic        RDB,
   output logic        WRB,
   output logic        CSB
);

   localparam int CW = 8;
   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CE - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CE - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CE - 1);

   e_hbus_st    st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [12:0] beats_q, beats_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [12:0] a_d, a_nxt;
   logic [7:0]  dbo_d, rdata_d;
   logic        dboe_d, rdb_d, wrb_d, csb_d, rspv_d;
   hbus_req_t   req;

   assign req       = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA, count: REQ_COUNT};
   assign REQ_READY = RESB && (st_q == HBUS_IDLE);
   assign RSP_ERR   = err_q;
   assign a_nxt     = A + 13'd1;

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      beats_d = beats_q;
      we_d    = we_q;
      err_d   = err_q;
      a_d     = A;
      dbo_d   = DB_O;
      dboe_d  = DB_OE;
      rdb_d   = RDB;
      wrb_d   = WRB;
      csb_d   = CSB;
      rdata_d = RSP_RDATA;
      rspv_d  = 1'b0;
      case (st_q)
         HBUS_IDLE: if (REQ_VALID) begin
            // Address and chip select go out on the accepting edge, ahead of SETUP.
            st_d    = HBUS_SETUP;
            cnt_d   = SETUP_LD;
            beats_d = req.we ? req.count : 13'd0;
            we_d    = req.we;
            err_d   = is_unmapped(req.addr);
            a_d     = req.addr;
            csb_d   = 1'b0;
            dboe_d  = req.we;
            dbo_d   = req.we ? req.wdata : 8'h00;
         end
         HBUS_SETUP: if (CE) begin
            if (cnt_q == '0) begin
               st_d  = HBUS_STROBE;
               cnt_d = STROBE_LD;
               rdb_d = we_q;
               wrb_d = !we_q;
            end else cnt_d = cnt_q - CW'(1);
         end
         HBUS_STROBE: if (CE) begin
            if (cnt_q == '0) begin
               st_d  = HBUS_HOLD;
               cnt_d = HOLD_LD;
               rdb_d = 1'b1;
               wrb_d = 1'b1;
               if (!we_q) rdata_d = DB_I;
            end else cnt_d = cnt_q - CW'(1);
         end
         HBUS_HOLD: if (CE) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else if (beats_q != 13'd0) begin
               // Next fill beat: CSB stays low, address wraps at 13 bits.
               st_d    = HBUS_SETUP;
               cnt_d   = SETUP_LD;
               beats_d = beats_q - 13'd1;
               a_d     = a_nxt;
               err_d   = err_q | is_unmapped(a_nxt);
            end else begin
               st_d   = HBUS_IDLE;
               rspv_d = 1'b1;
               csb_d  = 1'b1;
               dboe_d = 1'b0;
               dbo_d  = 8'h00;
               a_d    = 13'd0;
            end
         end
         default: st_d = HBUS_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESB) begin
         st_q      <= HBUS_IDLE;
         cnt_q     <= '0;
         beats_q   <= 13'd0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         A         <= 13'd0;
         DB_O      <= 8'h00;
         DB_OE     <= 1'b0;
         RDB       <= 1'b1;
         WRB       <= 1'b1;
         CSB       <= 1'b1;
         RSP_RDATA <= 8'h00;
         RSP_VALID <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         beats_q   <= beats_d;
         we_q      <= we_d;
         err_q     <= err_d;
         A         <= a_d;
         DB_O      <= dbo_d;
         DB_OE     <= dboe_d;
         RDB       <= rdb_d;
         WRB       <= wrb_d;
         CSB       <= csb_d;
         RSP_RDATA <= rdata_d;
         RSP_VALID <= rspv_d;
      end
   end

endmodule
